multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 Op  input  7  opcode field of the instruction register.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completes the current access this cycle.
REQ-007 mem_req  output  1  memory access request.
REQ-008 PCWrite  output  1  PC register enable.
REQ-009 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 IRWrite  output  1  instruction register and OldPC enable.
REQ-011 MemWrite  output  1  data memory write strobe.
REQ-012 RegWrite  output  1  register file write enable.
REQ-013 ResultSrc  output  2  result mux select: 00 = ALUOut, 01 = ReadData, 10 = ALUResult.
REQ-014 ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 data.
REQ-015 ALUSrcB  output  2  ALU B select: 00 = rs2 data, 01 = immediate, 10 = constant 4.
REQ-016 ALUOp  output  2  00 = add, 01 = subtract, 10 = funct-decoded.
REQ-017 ImmSrc  output  2  immediate format select.
REQ-018 state  output  4  current state encoding, for debug.
REQ-019 illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded.

Function
REQ-020 The FSM SHALL have these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, BEQ=8; encodings 9-15 SHALL return to FETCH on the next edge.
REQ-021 State transitions SHALL be:
- FETCH to DECODE when mem_ready=1, else stay in FETCH.
- DECODE by Op: 0000011 or 0100011 to MEMADR; 0110011 to EXECR; 1100011 to BEQ; any other Op to FETCH.
- MEMADR to MEMREAD when Op=0000011, else to MEMWRITE.
- MEMREAD to MEMWB when mem_ready=1, else stay in MEMREAD.
- MEMWRITE to FETCH when mem_ready=1, else stay in MEMWRITE.
- MEMWB, ALUWB and BEQ to FETCH.
- EXECR to ALUWB.
REQ-022 Outputs SHALL be Moore functions of state, gated only as stated in REQ-030; every output not listed for a state SHALL be 0:
- FETCH: mem_req=1, AdrSrc=0, IRWrite=mem_ready, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: mem_req=1, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
REQ-023 PCWrite SHALL equal (state==FETCH & mem_ready) | (state==BEQ & Zero).
REQ-024 ImmSrc SHALL be a combinational function of Op: 0100011 gives 01, 1100011 gives 10, any other Op gives 00.
REQ-025 illegal_op SHALL be asserted for exactly the one cycle in which state==DECODE and Op is unsupported.
REQ-026 Instruction length in cycles with zero wait states SHALL be: lw 5, sw 4, R-type 4, beq 3, unsupported 2.
REQ-027 Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE SHALL add exactly one cycle and SHALL hold all outputs stable; IRWrite and PCWrite stay 0 during FETCH wait cycles.
REQ-028 mem_ready SHALL be ignored in all states other than FETCH, MEMREAD and MEMWRITE.
REQ-029 In BEQ, Zero SHALL be sampled in the BEQ cycle only.

Reset
REQ-030 While rst=0, state SHALL be FETCH and PCWrite, IRWrite, MemWrite, RegWrite, mem_req and illegal_op SHALL be 0; the other outputs SHALL take their FETCH values.
REQ-031 rst asserted in any state, including mid-wait in MEMWRITE, SHALL force FETCH immediately, with no further write strobe.
REQ-032 The first rising edge after rst deasserts SHALL be evaluated as a FETCH cycle.

Verification
REQ-033 lw (Op=0000011), mem_ready=1 throughout -> states 0,1,2,3,4,0; RegWrite=1 only in state 4; ResultSrc=01 in state 4.
REQ-034 sw (Op=0100011), mem_ready low for 2 cycles in MEMWRITE -> MemWrite=1 for 3 cycles, then FETCH; ImmSrc=01.
REQ-035 beq (Op=1100011): Zero=1 -> PCWrite=1 in BEQ cycle; Zero=0 -> PCWrite=0; both take 3 cycles back to FETCH.
REQ-036 Op=1111111 -> illegal_op high for 1 cycle in DECODE, then FETCH; no RegWrite or MemWrite asserted.
REQ-037 FETCH with mem_ready=0 for 3 cycles -> IRWrite=0 and PCWrite=0 for those cycles, then 1 for one cycle when mem_ready=1.
REQ-038 rst pulled low in state MEMWRITE with mem_ready=0 -> state=0 and MemWrite=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - status inputs and control outputs of the multicycle controller
// master is the controller; slave is the datapath/memory side.
interface multicycle_controller_if;
  logic [6:0] Op;
  logic       Zero;
  logic       mem_ready;

  logic       mem_req;
  logic       PCWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic [3:0] state;
  logic       illegal_op;

  modport master (
    input  Op, Zero, mem_ready,
    output mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, state, illegal_op
  );

  modport slave (
    output Op, Zero, mem_ready,
    input  mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, state, illegal_op
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing a multicycle RISC-V datapath
// Strobes are masked by rst so they drop the moment reset asserts, not at the next edge.
module multicycle_controller (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       w_op_mem;
  logic       w_op_supported;
  logic       w_mem_req;
  logic       w_pc_write;
  logic       w_adr_src;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_illegal;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_imm_src;

  always_comb begin
    w_op_mem       = (bus.Op == OP_LW) || (bus.Op == OP_SW);
    w_op_supported = w_op_mem || (bus.Op == OP_R) || (bus.Op == OP_BEQ);
  end

  always_comb begin
    w_imm_src = 2'b00;
    if (bus.Op == OP_SW) begin
      w_imm_src = 2'b01;
    end else if (bus.Op == OP_BEQ) begin
      w_imm_src = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = S_FETCH;
    w_mem_req    = 1'b0;
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;

    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_next       = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        w_illegal   = ~w_op_supported;
        if (w_op_mem) begin
          w_next = S_MEMADR;
        end else if (bus.Op == OP_R) begin
          w_next = S_EXECR;
        end else if (bus.Op == OP_BEQ) begin
          w_next = S_BEQ;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = (bus.Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        w_next    = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_next      = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b00;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_pc_write  = bus.Zero;
        w_next      = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  always_comb begin
    bus.mem_req    = rst & w_mem_req;
    bus.PCWrite    = rst & w_pc_write;
    bus.IRWrite    = rst & w_ir_write;
    bus.MemWrite   = rst & w_mem_write;
    bus.RegWrite   = rst & w_reg_write;
    bus.illegal_op = rst & w_illegal;
    bus.AdrSrc     = w_adr_src;
    bus.ResultSrc  = w_result_src;
    bus.ALUSrcA    = w_alu_src_a;
    bus.ALUSrcB    = w_alu_src_b;
    bus.ALUOp      = w_alu_op;
    bus.ImmSrc     = w_imm_src;
    bus.state      = r_state;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_controller_if bus();
  multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic       z;
    logic [6:0] op;
  } cyc_t;

  cyc_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_memw, n_regw, n_irw, n_pcw, n_ill;

  logic [6:0] v_op  [9] = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BEQ, 7'h7F, OP_SW, OP_LW, 7'b0010011};
  logic       v_z   [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int         v_fw  [9] = '{0, 0, 0, 0, 0, 0, 0, 3, 0};
  int         v_mw  [9] = '{0, 0, 0, 0, 0, 0, 2, 1, 0};
  int         v_len [9] = '{5, 4, 4, 3, 3, 2, 6, 9, 2};
  int         v_memw[9] = '{0, 1, 0, 0, 0, 0, 3, 0, 0};
  int         v_regw[9] = '{1, 0, 1, 0, 0, 0, 0, 1, 0};
  int         v_pcw [9] = '{1, 1, 1, 2, 1, 1, 1, 1, 1};
  int         v_ill [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 1};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic cyc_t mk(input logic [3:0] st, input logic mr, input logic z, input logic [6:0] op);
    cyc_t c;
    c.st = st;
    c.mr = mr;
    c.z  = z;
    c.op = op;
    return c;
  endfunction

  // {state, mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op}
  function automatic logic [20:0] model_out(input cyc_t c);
    logic mreq, pcw, adr, irw, mw, rw, ill;
    logic [1:0] res, a, b, aop, imm;
    logic known;
    mreq = 0; pcw = 0; adr = 0; irw = 0; mw = 0; rw = 0; ill = 0;
    res = 0; a = 0; b = 0; aop = 0;
    known = (c.op == OP_LW) || (c.op == OP_SW) || (c.op == OP_R) || (c.op == OP_BEQ);
    imm = (c.op == OP_SW) ? 2'b01 : (c.op == OP_BEQ) ? 2'b10 : 2'b00;
    case (c.st)
      4'd0: begin mreq = 1; irw = c.mr; pcw = c.mr; b = 2'b10; res = 2'b10; end
      4'd1: begin a = 2'b01; b = 2'b01; ill = ~known; end
      4'd2: begin a = 2'b10; b = 2'b01; end
      4'd3: begin mreq = 1; adr = 1; end
      4'd4: begin res = 2'b01; rw = 1; end
      4'd5: begin mreq = 1; adr = 1; mw = 1; end
      4'd6: begin a = 2'b10; aop = 2'b10; end
      4'd7: begin rw = 1; end
      4'd8: begin a = 2'b10; aop = 2'b01; pcw = c.z; end
      default: ;
    endcase
    return {c.st, mreq, pcw, adr, irw, mw, rw, res, a, b, aop, imm, ill};
  endfunction

  always @(negedge clk) begin
    cyc_t rec;
    logic [20:0] want;
    logic [20:0] got;
    #2;
    if (q.size() > 0) begin
      rec  = q.pop_front();
      want = model_out(rec);
      got  = {bus.state, bus.mem_req, bus.PCWrite, bus.AdrSrc, bus.IRWrite, bus.MemWrite,
              bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc,
              bus.illegal_op};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t op=%b exp_state=%0d got=%h want=%h", $time, rec.op, rec.st, got, want);
      end
      if (bus.MemWrite)   n_memw++;
      if (bus.RegWrite)   n_regw++;
      if (bus.IRWrite)    n_irw++;
      if (bus.PCWrite)    n_pcw++;
      if (bus.illegal_op) n_ill++;
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int mw,
                           input int limit, output int len);
    cyc_t seq[$];
    int   n;
    for (int i = 0; i < fw; i++) seq.push_back(mk(4'd0, 1'b0, rb(), op));
    seq.push_back(mk(4'd0, 1'b1, rb(), op));
    seq.push_back(mk(4'd1, rb(), rb(), op));
    if (op == OP_LW) begin
      seq.push_back(mk(4'd2, rb(), rb(), op));
      for (int i = 0; i < mw; i++) seq.push_back(mk(4'd3, 1'b0, rb(), op));
      seq.push_back(mk(4'd3, 1'b1, rb(), op));
      seq.push_back(mk(4'd4, rb(), rb(), op));
    end else if (op == OP_SW) begin
      seq.push_back(mk(4'd2, rb(), rb(), op));
      for (int i = 0; i < mw; i++) seq.push_back(mk(4'd5, 1'b0, rb(), op));
      seq.push_back(mk(4'd5, 1'b1, rb(), op));
    end else if (op == OP_R) begin
      seq.push_back(mk(4'd6, rb(), rb(), op));
      seq.push_back(mk(4'd7, rb(), rb(), op));
    end else if (op == OP_BEQ) begin
      seq.push_back(mk(4'd8, rb(), z, op));
    end
    len = seq.size();
    n = (limit > 0 && limit < len) ? limit : len;
    n_memw = 0; n_regw = 0; n_irw = 0; n_pcw = 0; n_ill = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.Op        = seq[i].op;
      bus.mem_ready = seq[i].mr;
      bus.Zero      = seq[i].z;
      q.push_back(seq[i]);
    end
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len;
    rst           = 1'b0;
    bus.mem_ready = 1'b1;
    bus.Zero      = 1'b1;
    bus.Op        = OP_BEQ;
    #12;
    check("reset_state",     int'(bus.state),     0);
    check("reset_mem_req",   int'(bus.mem_req),   0);
    check("reset_PCWrite",   int'(bus.PCWrite),   0);
    check("reset_IRWrite",   int'(bus.IRWrite),   0);
    check("reset_ALUSrcB",   int'(bus.ALUSrcB),   2);
    check("reset_ResultSrc", int'(bus.ResultSrc), 2);
    check("reset_ImmSrc",    int'(bus.ImmSrc),    2);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst = 1'b1;

    for (int v = 0; v < 9; v++) begin
      run_instr(v_op[v], v_z[v], v_fw[v], v_mw[v], 0, len);
      check($sformatf("len_v%0d", v),      len,    v_len[v]);
      check($sformatf("memwrite_v%0d", v), n_memw, v_memw[v]);
      check($sformatf("regwrite_v%0d", v), n_regw, v_regw[v]);
      check($sformatf("irwrite_v%0d", v),  n_irw,  1);
      check($sformatf("pcwrite_v%0d", v),  n_pcw,  v_pcw[v]);
      check($sformatf("illegal_v%0d", v),  n_ill,  v_ill[v]);
    end

    // stall in MEMWRITE, then assert reset between clock edges
    run_instr(OP_SW, 1'b0, 0, 5, 4, len);
    check("pre_reset_state", int'(bus.state), 5);
    rst = 1'b0;
    #1;
    check("async_reset_state",    int'(bus.state),    0);
    check("async_reset_memwrite", int'(bus.MemWrite), 0);
    check("async_reset_mem_req",  int'(bus.mem_req),  0);
    @(negedge clk);
    check("held_reset_state", int'(bus.state), 0);
    bus.mem_ready = 1'b0;
    rst = 1'b1;

    run_instr(OP_R, 1'b0, 1, 0, 0, len);
    check("post_reset_len",      len,    5);
    check("post_reset_regwrite", n_regw, 1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
